// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: bus-mapped controller for a 6-digit multiplexed 7-segment display.
// Holds the digit nibbles, decimal points and control bits in registers. When enabled,
// it scans one digit every SCAN_DIV clocks.
// Ports:
//   clk, nrst       clock and synchronous active-low reset
//   bus_addr        byte offset within the block (word-aligned; bits [1:0] ignored)
//   bus_wen/ren     single-cycle write/read requests
//   bus_wdata       write data
//   bus_rdata       registered read data, valid while bus_ack=1
//   bus_ack         one-cycle response strobe, one cycle after each request
//   seg_data        active-low segments, [6:0]=g..a, [7]=dp
//   seg_sel         active-low one-hot digit select
module seg7_display_ctrl #(
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned CNT_W    = 15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [7:0]  seg_data,
  output logic [5:0]  seg_sel
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned LAST_IDX = 5;

  localparam logic [1:0] REG_DIGITS = 2'd0;
  localparam logic [1:0] REG_DP     = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [23:0]      digits_q;
  logic [5:0]       dp_q;
  logic [1:0]       ctrl_q;
  logic [CNT_W-1:0] presc_q;
  logic [IDX_W-1:0] idx_q;

  logic             en_c;
  logic             raw_c;
  logic [1:0]       word_c;
  logic [31:0]      rdata_nxt_c;
  logic [CNT_W-1:0] presc_nxt_c;
  logic [IDX_W-1:0] idx_nxt_c;
  logic [3:0]       nib_c;
  logic             dp_bit_c;
  logic [6:0]       seg7_c;
  logic [7:0]       seg_data_nxt_c;
  logic [5:0]       seg_sel_nxt_c;
  logic             unused_bits_c;

  assign en_c   = ctrl_q[0];
  assign raw_c  = ctrl_q[1];
  assign word_c = bus_addr[3:2];

  // Address byte-lane bits and the upper write-data byte have no storage behind them.
  assign unused_bits_c = ^{bus_addr[1:0], bus_wdata[31:24]};

  // Read mux; a read that coincides with a write returns zero.
  always_comb begin
    rdata_nxt_c = 32'h0;
    if (bus_ren && !bus_wen) begin
      case (word_c)
        REG_DIGITS: rdata_nxt_c = {8'h0, digits_q};
        REG_DP:     rdata_nxt_c = {26'h0, dp_q};
        REG_CTRL:   rdata_nxt_c = {30'h0, ctrl_q};
        REG_STATUS: rdata_nxt_c = {29'h0, idx_q};
        default:    rdata_nxt_c = 32'h0;
      endcase
    end
  end

  // Prescaler and digit index; both are held at zero while scanning is disabled.
  always_comb begin
    presc_nxt_c = '0;
    idx_nxt_c   = '0;
    if (en_c) begin
      if (presc_q == CNT_W'(SCAN_DIV - 1)) begin
        presc_nxt_c = '0;
        idx_nxt_c   = (idx_q == IDX_W'(LAST_IDX)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        presc_nxt_c = presc_q + CNT_W'(1);
        idx_nxt_c   = idx_q;
      end
    end
  end

  // Select the nibble and decimal point of the digit currently being scanned.
  always_comb begin
    nib_c    = 4'h0;
    dp_bit_c = 1'b0;
    case (idx_q)
      3'd0: begin nib_c = digits_q[3:0];   dp_bit_c = dp_q[0]; end
      3'd1: begin nib_c = digits_q[7:4];   dp_bit_c = dp_q[1]; end
      3'd2: begin nib_c = digits_q[11:8];  dp_bit_c = dp_q[2]; end
      3'd3: begin nib_c = digits_q[15:12]; dp_bit_c = dp_q[3]; end
      3'd4: begin nib_c = digits_q[19:16]; dp_bit_c = dp_q[4]; end
      3'd5: begin nib_c = digits_q[23:20]; dp_bit_c = dp_q[5]; end
      default: begin nib_c = 4'h0; dp_bit_c = 1'b0; end
    endcase
  end

  // Hex to active-low g..a segment pattern.
  always_comb begin
    seg7_c = 7'h7F;
    case (nib_c)
      4'h0: seg7_c = 7'h40;
      4'h1: seg7_c = 7'h79;
      4'h2: seg7_c = 7'h24;
      4'h3: seg7_c = 7'h30;
      4'h4: seg7_c = 7'h19;
      4'h5: seg7_c = 7'h12;
      4'h6: seg7_c = 7'h02;
      4'h7: seg7_c = 7'h78;
      4'h8: seg7_c = 7'h00;
      4'h9: seg7_c = 7'h10;
      4'hA: seg7_c = 7'h08;
      4'hB: seg7_c = 7'h03;
      4'hC: seg7_c = 7'h46;
      4'hD: seg7_c = 7'h21;
      4'hE: seg7_c = 7'h06;
      4'hF: seg7_c = 7'h0E;
      default: seg7_c = 7'h7F;
    endcase
  end

  // Next display outputs; raw mode bypasses the decoder on digit 0 only.
  always_comb begin
    seg_data_nxt_c = 8'hFF;
    seg_sel_nxt_c  = 6'h3F;
    if (en_c) begin
      seg_sel_nxt_c = ~(6'b1 << idx_q);
      if (raw_c && (idx_q == '0)) begin
        seg_data_nxt_c = ~digits_q[7:0];
      end else begin
        seg_data_nxt_c = {~dp_bit_c, seg7_c};
      end
    end
  end

  // Register file, bus response and scan state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      digits_q  <= '0;
      dp_q      <= '0;
      ctrl_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      seg_data  <= 8'hFF;
      seg_sel   <= 6'h3F;
    end else begin
      if (bus_wen) begin
        case (word_c)
          REG_DIGITS: digits_q <= bus_wdata[23:0];
          REG_DP:     dp_q     <= bus_wdata[5:0];
          REG_CTRL:   ctrl_q   <= bus_wdata[1:0];
          default:    ;
        endcase
      end
      bus_ack   <= bus_wen | bus_ren;
      bus_rdata <= rdata_nxt_c;
      presc_q   <= presc_nxt_c;
      idx_q     <= idx_nxt_c;
      seg_data  <= seg_data_nxt_c;
      seg_sel   <= seg_sel_nxt_c;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: directed bench for seg7_display_ctrl with SCAN_DIV=4.
module tb_seg7_display_ctrl;

  logic        clk;
  logic        nrst;
  logic [3:0]  bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  seg_data;
  logic [5:0]  seg_sel;

  int total = 0;
  int bad   = 0;

  seg7_display_ctrl #(.SCAN_DIV(4), .CNT_W(2)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus_addr  (bus_addr),
    .bus_wen   (bus_wen),
    .bus_ren   (bus_ren),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .seg_data  (seg_data),
    .seg_sel   (seg_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_wen   = 1'b0;
    bus_ren   = 1'b0;
    bus_addr  = 4'h0;
    bus_wdata = 32'h0;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_wen   = 1'b1;
    tick();
    check("wr_ack", 32'(bus_ack), 32'h1);
    check("wr_rdata", bus_rdata, 32'h0);
    idle();
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    bus_addr = addr;
    bus_ren  = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(bus_ack), 32'h1);
    check(tag, bus_rdata, exp);
    idle();
  endtask

  // Advance until the given digit is selected, bounded by a cycle budget.
  task automatic wait_sel(input logic [5:0] target, input string tag);
    int n = 0;
    while (seg_sel !== target && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(seg_sel), 32'(target));
  endtask

  logic [7:0] exp_seg [6];
  logic [5:0] exp_sel;

  initial begin
    exp_seg[0] = 8'hC0; exp_seg[1] = 8'hF9; exp_seg[2] = 8'hA4;
    exp_seg[3] = 8'hB0; exp_seg[4] = 8'h99; exp_seg[5] = 8'h92;

    // Reset held two cycles.
    idle();
    nrst = 1'b0;
    tick();
    tick();
    check("rst_sel", 32'(seg_sel), 32'h3F);
    check("rst_data", 32'(seg_data), 32'hFF);
    check("rst_ack", 32'(bus_ack), 32'h0);
    nrst = 1'b1;
    bus_read(4'h0, 32'h0, "rst_digits");
    bus_read(4'h4, 32'h0, "rst_dp");
    bus_read(4'h8, 32'h0, "rst_ctrl");
    tick();
    check("ack_single", 32'(bus_ack), 32'h0);

    // Full scan of 543210, each slot held four clocks, then wrap to digit 0.
    bus_write(4'h0, 32'h0054_3210);
    bus_write(4'h8, 32'h1);
    for (int d = 0; d < 6; d++) begin
      exp_sel = ~(6'b1 << d);
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("scan_sel_d%0d_k%0d", d, k), 32'(seg_sel), 32'(exp_sel));
        check($sformatf("scan_data_d%0d_k%0d", d, k), 32'(seg_data), 32'(exp_seg[d]));
      end
    end
    tick();
    check("scan_wrap_sel", 32'(seg_sel), 32'h3E);
    check("scan_wrap_data", 32'(seg_data), 32'hC0);

    // Decimal point on digit 2 and hex A.
    bus_write(4'h4, 32'h0000_0004);
    bus_write(4'h0, 32'h0054_3A10);
    tick();
    wait_sel(6'h3B, "dp_wait_d2");
    check("dp_d2_data", 32'(seg_data), 32'h08);
    wait_sel(6'h37, "dp_wait_d3");
    check("dp_d3_data", 32'(seg_data), 32'hB0);
    wait_sel(6'h1F, "dp_wait_d5");
    check("dp_d5_data", 32'(seg_data), 32'h92);
    wait_sel(6'h3E, "dp_wait_wrap");
    check("dp_wrap_data", 32'(seg_data), 32'hC0);

    // Back-to-back reads, then simultaneous write and read.
    bus_addr = 4'h0;
    bus_ren  = 1'b1;
    tick();
    check("b2b_ack0", 32'(bus_ack), 32'h1);
    check("b2b_rdata0", bus_rdata, 32'h0054_3A10);
    bus_addr = 4'h8;
    tick();
    check("b2b_ack1", 32'(bus_ack), 32'h1);
    check("b2b_rdata1", bus_rdata, 32'h1);
    idle();
    tick();
    check("b2b_ack_end", 32'(bus_ack), 32'h0);
    bus_addr  = 4'h4;
    bus_wdata = 32'hFFFF_FF00;
    bus_wen   = 1'b1;
    bus_ren   = 1'b1;
    tick();
    check("wr_rd_ack", 32'(bus_ack), 32'h1);
    check("wr_rd_rdata", bus_rdata, 32'h0);
    idle();
    bus_read(4'h4, 32'h0, "wr_rd_dp");
    bus_write(4'hC, 32'h7);
    bus_read(4'h0, 32'h0054_3A10, "status_wr_digits");
    bus_read(4'h8, 32'h1, "status_wr_ctrl");
    bus_write(4'h0, 32'hAB54_3210);
    bus_read(4'h0, 32'h0054_3210, "digits_mask");

    // Raw mode on digit 0, then disable.
    bus_write(4'h8, 32'h3);
    bus_write(4'h0, 32'h0054_327F);
    tick();
    wait_sel(6'h3E, "raw_wait_d0");
    check("raw_d0_data", 32'(seg_data), 32'h80);
    wait_sel(6'h3D, "raw_wait_d1");
    check("raw_d1_data", 32'(seg_data), 32'hF8);
    bus_write(4'h8, 32'h0);
    tick();
    check("dis_sel", 32'(seg_sel), 32'h3F);
    check("dis_data", 32'(seg_data), 32'hFF);
    bus_read(4'hC, 32'h0, "dis_status");

    // Reset in the middle of digit 3 with a read in flight.
    bus_write(4'h8, 32'h1);
    wait_sel(6'h37, "mid_wait_d3");
    nrst     = 1'b0;
    bus_addr = 4'h8;
    bus_ren  = 1'b1;
    tick();
    check("mid_rst_sel", 32'(seg_sel), 32'h3F);
    check("mid_rst_data", 32'(seg_data), 32'hFF);
    check("mid_rst_ack", 32'(bus_ack), 32'h0);
    check("mid_rst_rdata", bus_rdata, 32'h0);
    nrst = 1'b1;
    idle();
    bus_read(4'h0, 32'h0, "mid_rst_digits");
    bus_read(4'h4, 32'h0, "mid_rst_dp");
    bus_read(4'h8, 32'h0, "mid_rst_ctrl");
    bus_read(4'hC, 32'h0, "mid_rst_status");
    tick();
    check("mid_rst_blank", 32'(seg_sel), 32'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
